l1_line_burst: RTL and testbench

//  Downstream neighbour of the L1-side MMU: converts one 256-bit cache-line read/write

---
 rtl/l1_line_burst_if.sv | 52 +++++
 rtl/l1_line_burst.sv | 150 +++++++++++++++
 tb/tb_l1_line_burst.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_line_burst_if.sv
// Interfaces for l1_line_burst: the line-request side (towards the L1 MMU)
// and the word-beat side (towards backing memory). Both sides carry plain
// level/pulse signals; see l1_line_burst for the protocol.
//
// l1_line_req_if
//   master = requester : req_read, req_write, req_addr, req_wdata
//   slave  = burst unit: read_done, write_done, read_data, burst_err
// l1_word_mem_if
//   master = burst unit: mem_req, mem_we, mem_addr, mem_wdata
//   slave  = memory    : mem_ready, mem_rdata

interface l1_line_req_if #(
    parameter int WORDS = 8
);
    logic                  req_read;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [WORDS*32-1:0]   req_wdata;
    logic                  read_done;
    logic                  write_done;
    logic [WORDS*32-1:0]   read_data;
    logic                  burst_err;

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        input  read_done, write_done, read_data, burst_err
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        output read_done, write_done, read_data, burst_err
    );
endinterface

interface l1_word_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/l1_line_burst.sv
// Purpose : split one cache-line read/write into WORDS sequential 32-bit memory beats.
// Latency : accept edge 0, beats from cycle 1 (one per cycle at zero wait), done pulse after last beat.
// Backpr. : each beat holds mem_req until mem_ready; a beat stalled MAX_WAIT cycles aborts with burst_err.
//
// Ports
//   sys_clk, rst : clock (rising edge) and synchronous active-high reset
//   req (slave)  : line request in (req_read/req_write level, held until done),
//                  read_done/write_done 1-cycle pulses, read_data line, burst_err
//   mem (master) : word beat out (mem_req held until mem_ready), mem_rdata in

module l1_line_burst #(
    parameter int WORDS    = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic          sys_clk,
    input  logic          rst,
    l1_line_req_if.slave  req,
    l1_word_mem_if.master mem
);

    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    // Byte-offset bits inside one line are cleared to form the line base.
    localparam logic [31:0] LINE_MASK = ~(32'(WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             base_q, base_d;
    logic [WORDS-1:0][31:0]  wdata_q, wdata_d;
    logic [WORDS-1:0][31:0]  rdata_q, rdata_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [CW-1:0]           wait_q, wait_d;

    logic accept;
    logic beat_fire;
    logic last_beat;
    logic timeout;

    // Write has priority when both request levels are high; the read is simply
    // not accepted and the requester reissues it.
    assign accept    = (state_q == IDLE) && (req.req_write || req.req_read);
    assign beat_fire = (state_q == BURST) && mem.mem_ready;
    assign last_beat = (beat_q == BW'(WORDS - 1));
    // The stall that would bring the wait count up to MAX_WAIT ends the burst.
    assign timeout   = (state_q == BURST) && !mem.mem_ready &&
                       (wait_q == CW'(MAX_WAIT - 1));

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if ((beat_fire && last_beat) || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        if (accept) begin
            // Request fields are captured once; later changes are ignored.
            base_d  = req.req_addr & LINE_MASK;
            wdata_d = req.req_wdata;
            we_d    = req.req_write;
            err_d   = 1'b0;
            beat_d  = '0;
            wait_d  = '0;
        end else if (beat_fire) begin
            // Only beats actually received update the line; an aborted read
            // leaves the remaining words at their previous values.
            if (!we_q) rdata_d[beat_q] = mem.mem_rdata;
            wait_d = '0;
            if (!last_beat) beat_d = beat_q + BW'(1);
        end else if (timeout) begin
            err_d = 1'b1;
        end else if (state_q == BURST) begin
            wait_d = wait_q + CW'(1);
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        req.read_done  = 1'b0;
        req.write_done = 1'b0;
        req.burst_err  = 1'b0;
        if (state_q == BURST) begin
            // mem_req stays high across beats so back-to-back beats need no gap.
            mem.mem_req   = 1'b1;
            mem.mem_we    = we_q;
            mem.mem_addr  = base_q + (32'(beat_q) << 2);
            mem.mem_wdata = we_q ? wdata_q[beat_q] : 32'd0;
        end
        if (state_q == DONE) begin
            req.read_done  = !we_q;
            req.write_done = we_q;
            req.burst_err  = err_q;
        end
    end

    assign req.read_data = rdata_q;

endmodule

// File: tb/tb_l1_line_burst.sv
module tb_l1_line_burst;
    localparam int WORDS    = 8;
    localparam int MAX_WAIT = 4;
    localparam int LW       = WORDS * 32;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    l1_line_req_if #(.WORDS(WORDS)) req_if();
    l1_word_mem_if                  mem_if();

    l1_line_burst #(.WORDS(WORDS), .MAX_WAIT(MAX_WAIT)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .req     (req_if),
        .mem     (mem_if)
    );

    int vec  = 0;
    int errs = 0;

    // What the memory model observed during one transaction.
    logic [31:0] b_addr [WORDS];
    logic        b_we   [WORDS];
    logic [31:0] b_wd   [WORDS];
    int   nbeats, ndone, done_cyc;
    logic got_rd, got_wr, got_err, req_at_done, req_after_done, stray_err;
    logic [LW-1:0] line2;

    function automatic logic [LW-1:0] seq_line(input logic [31:0] first);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < WORDS; i++) l[32*i +: 32] = first + 32'(i);
        return l;
    endfunction

    function automatic logic [LW-1:0] xor_line(input logic [31:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < WORDS; i++) l[32*i +: 32] = (base + 32'(4*i)) ^ 32'h0000_FFFF;
        return l;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 (after accept edge 0).
    task automatic start(input logic rd, input logic wr, input logic [31:0] addr, input logic [LW-1:0] wd);
        req_if.req_read  = rd;
        req_if.req_write = wr;
        req_if.req_addr  = addr;
        req_if.req_wdata = wd;
        @(posedge sys_clk); @(negedge sys_clk);
    endtask

    // Memory model: each beat sees `waits` stall cycles then ready (never if `never`).
    // Returns at the negedge of the cycle following the done pulse, requests dropped.
    task automatic serve(input int waits, input logic never, input int budget);
        int wc;
        wc = 0; nbeats = 0; ndone = 0; done_cyc = 0;
        got_rd = 0; got_wr = 0; got_err = 0; req_at_done = 0; req_after_done = 1; stray_err = 0;
        for (int c = 1; c <= budget; c++) begin
            if (req_if.read_done || req_if.write_done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc    = c;
                    got_rd      = req_if.read_done;
                    got_wr      = req_if.write_done;
                    got_err     = req_if.burst_err;
                    req_at_done = mem_if.mem_req;
                end
                req_if.req_read  = 1'b0;
                req_if.req_write = 1'b0;
            end else if (req_if.burst_err) begin
                stray_err = 1'b1;
            end
            mem_if.mem_ready = 1'b0;
            if (done_cyc != 0 && c == done_cyc + 1) begin
                req_after_done = mem_if.mem_req;
                break;
            end
            if (mem_if.mem_req && !never) begin
                if (wc == waits) begin
                    if (nbeats < WORDS) begin
                        b_addr[nbeats] = mem_if.mem_addr;
                        b_we[nbeats]   = mem_if.mem_we;
                        b_wd[nbeats]   = mem_if.mem_wdata;
                    end
                    nbeats++;
                    mem_if.mem_ready = 1'b1;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
            mem_if.mem_rdata = mem_if.mem_addr ^ 32'h0000_FFFF;
            @(posedge sys_clk); @(negedge sys_clk);
        end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge sys_clk); @(negedge sys_clk); end
        vec++; if (mem_if.mem_req !== 1'b0)   begin errs++; $display("FAIL rst_mem_req: got %b want 0", mem_if.mem_req); end
        vec++; if (mem_if.mem_we !== 1'b0)    begin errs++; $display("FAIL rst_mem_we: got %b want 0", mem_if.mem_we); end
        vec++; if (mem_if.mem_addr !== 32'd0) begin errs++; $display("FAIL rst_mem_addr: got %h want 0", mem_if.mem_addr); end
        vec++; if (mem_if.mem_wdata !== 32'd0) begin errs++; $display("FAIL rst_mem_wdata: got %h want 0", mem_if.mem_wdata); end
        vec++; if ({req_if.read_done, req_if.write_done, req_if.burst_err} !== 3'b000)
            begin errs++; $display("FAIL rst_done_err: got %b want 000", {req_if.read_done, req_if.write_done, req_if.burst_err}); end
        vec++; if (req_if.read_data !== '0) begin errs++; $display("FAIL rst_read_data: got %h want 0", req_if.read_data); end
        rst = 1'b0;
        @(posedge sys_clk); @(negedge sys_clk);
    endtask

    task automatic test_write_zero_wait();
        start(1'b0, 1'b1, 32'h1000_0014, seq_line(32'hA0));
        // Changing the request after accept must not matter.
        req_if.req_addr  = 32'hDEAD_BEEF;
        req_if.req_wdata = '1;
        serve(0, 1'b0, 40);
        vec++; if (done_cyc != 9) begin errs++; $display("FAIL t1_done_cycle: got %0d want 9", done_cyc); end
        vec++; if ({got_wr, got_rd, got_err} !== 3'b100) begin errs++; $display("FAIL t1_done_kind: got wr/rd/err=%b want 100", {got_wr, got_rd, got_err}); end
        vec++; if (req_at_done !== 1'b0) begin errs++; $display("FAIL t1_req_at_done: got %b want 0", req_at_done); end
        vec++; if (nbeats != WORDS) begin errs++; $display("FAIL t1_beats: got %0d want %0d", nbeats, WORDS); end
        vec++; if (ndone != 1 || stray_err) begin errs++; $display("FAIL t1_pulses: got done=%0d stray_err=%b want 1/0", ndone, stray_err); end
        for (int i = 0; i < WORDS && i < nbeats; i++) begin
            vec++;
            if (b_addr[i] !== 32'h1000_0000 + 32'(4*i) || b_we[i] !== 1'b1 || b_wd[i] !== 32'hA0 + 32'(i)) begin
                errs++;
                $display("FAIL t1_beat%0d: got addr=%h we=%b wd=%h want addr=%h we=1 wd=%h",
                         i, b_addr[i], b_we[i], b_wd[i], 32'h1000_0000 + 32'(4*i), 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_read_wait_states();
        start(1'b1, 1'b0, 32'h0000_2000, '0);
        serve(2, 1'b0, 80);
        line2 = xor_line(32'h0000_2000);
        vec++; if (done_cyc != 25) begin errs++; $display("FAIL t2_done_cycle: got %0d want 25", done_cyc); end
        vec++; if ({got_wr, got_rd, got_err} !== 3'b010) begin errs++; $display("FAIL t2_done_kind: got wr/rd/err=%b want 010", {got_wr, got_rd, got_err}); end
        vec++; if (req_if.read_data !== line2) begin errs++; $display("FAIL t2_read_data: got %h want %h", req_if.read_data, line2); end
        vec++; if (nbeats != WORDS) begin errs++; $display("FAIL t2_beats: got %0d want %0d", nbeats, WORDS); end
        for (int i = 0; i < WORDS && i < nbeats; i++) begin
            vec++;
            if (b_addr[i] !== 32'h0000_2000 + 32'(4*i) || b_we[i] !== 1'b0) begin
                errs++; $display("FAIL t2_beat%0d: got addr=%h we=%b want addr=%h we=0", i, b_addr[i], b_we[i], 32'h0000_2000 + 32'(4*i));
            end
        end
    endtask

    task automatic test_timeout();
        start(1'b1, 1'b0, 32'h0000_4000, '0);
        serve(0, 1'b1, 40);
        vec++; if (done_cyc != MAX_WAIT + 1) begin errs++; $display("FAIL t3_done_cycle: got %0d want %0d", done_cyc, MAX_WAIT + 1); end
        vec++; if ({got_wr, got_rd, got_err} !== 3'b011) begin errs++; $display("FAIL t3_done_kind: got wr/rd/err=%b want 011", {got_wr, got_rd, got_err}); end
        vec++; if (req_at_done !== 1'b0) begin errs++; $display("FAIL t3_req_at_done: got %b want 0", req_at_done); end
        vec++; if (nbeats != 0) begin errs++; $display("FAIL t3_beats: got %0d want 0", nbeats); end
        vec++; if (req_if.burst_err !== 1'b0 || ndone != 1) begin errs++; $display("FAIL t3_err_after: got err=%b done=%0d want 0/1", req_if.burst_err, ndone); end
        // No beat arrived, so the previous line is untouched.
        vec++; if (req_if.read_data !== line2) begin errs++; $display("FAIL t3_read_data_kept: got %h want %h", req_if.read_data, line2); end
    endtask

    task automatic test_both_requests();
        start(1'b1, 1'b1, 32'h0000_5008, seq_line(32'h5000));
        serve(0, 1'b0, 40);
        vec++; if (done_cyc != 9) begin errs++; $display("FAIL t4_done_cycle: got %0d want 9", done_cyc); end
        vec++; if ({got_wr, got_rd, got_err} !== 3'b100) begin errs++; $display("FAIL t4_done_kind: got wr/rd/err=%b want 100", {got_wr, got_rd, got_err}); end
        vec++; if (nbeats != WORDS || ndone != 1) begin errs++; $display("FAIL t4_counts: got beats=%0d done=%0d want %0d/1", nbeats, ndone, WORDS); end
        for (int i = 0; i < WORDS && i < nbeats; i++) begin
            vec++;
            if (b_addr[i] !== 32'h0000_5000 + 32'(4*i) || b_we[i] !== 1'b1 || b_wd[i] !== 32'h5000 + 32'(i)) begin
                errs++; $display("FAIL t4_beat%0d: got addr=%h we=%b wd=%h", i, b_addr[i], b_we[i], b_wd[i]);
            end
        end
        vec++; if (req_if.read_data !== line2) begin errs++; $display("FAIL t4_read_data_kept: got %h want %h", req_if.read_data, line2); end
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        start(1'b0, 1'b1, 32'h0000_6000, seq_line(32'h6600));
        mem_if.mem_ready = 1'b1;
        repeat (3) begin @(posedge sys_clk); @(negedge sys_clk); end
        vec++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0000_600C) begin
            errs++; $display("FAIL t5_beat3: got req=%b addr=%h want 1/0000600c", mem_if.mem_req, mem_if.mem_addr); end
        rst = 1'b1;
        req_if.req_write = 1'b0;
        @(posedge sys_clk); @(negedge sys_clk);
        vec++; if ({mem_if.mem_req, mem_if.mem_we, req_if.read_done, req_if.write_done, req_if.burst_err} !== 5'b0
                   || mem_if.mem_addr !== 32'd0 || mem_if.mem_wdata !== 32'd0 || req_if.read_data !== '0) begin
            errs++; $display("FAIL t5_outputs_after_rst: got req=%b we=%b addr=%h wd=%h rdata=%h want all 0",
                             mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, req_if.read_data); end
        rst = 1'b0;
        mem_if.mem_ready = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_if.read_done || req_if.write_done || mem_if.mem_req) pulses++;
            @(posedge sys_clk); @(negedge sys_clk);
        end
        vec++; if (pulses != 0) begin errs++; $display("FAIL t5_no_done: got %0d active cycles want 0", pulses); end
        start(1'b1, 1'b0, 32'h0000_3044, '0);
        serve(0, 1'b0, 40);
        vec++; if (done_cyc != 9 || {got_wr, got_rd, got_err} !== 3'b010) begin
            errs++; $display("FAIL t5_read_done: got cycle=%0d wr/rd/err=%b want 9/010", done_cyc, {got_wr, got_rd, got_err}); end
        vec++; if (req_if.read_data !== xor_line(32'h0000_3040)) begin
            errs++; $display("FAIL t5_read_data: got %h want %h", req_if.read_data, xor_line(32'h0000_3040)); end
    endtask

    task automatic test_back_to_back();
        start(1'b0, 1'b1, 32'h8000_0000, seq_line(32'hC0));
        serve(0, 1'b0, 40);
        vec++; if (done_cyc != 9 || {got_wr, got_rd, got_err} !== 3'b100) begin
            errs++; $display("FAIL t6_write_done: got cycle=%0d wr/rd/err=%b want 9/100", done_cyc, {got_wr, got_rd, got_err}); end
        vec++; if (req_after_done !== 1'b0) begin errs++; $display("FAIL t6_idle_gap: got mem_req=%b want 0", req_after_done); end
        vec++; if (nbeats != WORDS || b_wd[0] !== 32'hC0 || b_wd[WORDS-1] !== 32'hC0 + 32'(WORDS-1)) begin
            errs++; $display("FAIL t6_write_beats: got beats=%0d wd0=%h wdN=%h", nbeats, b_wd[0], b_wd[WORDS-1]); end
        // Read re-asserted in the IDLE cycle right after write_done.
        start(1'b1, 1'b0, 32'hFFFF_FFFC, '0);
        serve(0, 1'b0, 40);
        vec++; if (done_cyc != 9 || {got_wr, got_rd, got_err} !== 3'b010) begin
            errs++; $display("FAIL t6_read_done: got cycle=%0d wr/rd/err=%b want 9/010", done_cyc, {got_wr, got_rd, got_err}); end
        vec++; if (nbeats != WORDS || b_addr[0] !== 32'hFFFF_FFE0 || b_addr[WORDS-1] !== 32'hFFFF_FFFC) begin
            errs++; $display("FAIL t6_read_addrs: got beats=%0d a0=%h aN=%h want %0d/ffffffe0/fffffffc", nbeats, b_addr[0], b_addr[WORDS-1], WORDS); end
        vec++; if (req_if.read_data !== xor_line(32'hFFFF_FFE0)) begin
            errs++; $display("FAIL t6_read_data: got %h want %h", req_if.read_data, xor_line(32'hFFFF_FFE0)); end
    endtask

    initial begin
        rst              = 1'b1;
        req_if.req_read  = 1'b0;
        req_if.req_write = 1'b0;
        req_if.req_addr  = '0;
        req_if.req_wdata = '0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = '0;
        line2            = '0;
        @(negedge sys_clk);
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_timeout();
        test_both_requests();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
